user_io_mc: RTL and testbench
=============================

Name: user_io_mc

Overview:
Second-generation IO-controller SPI slave. The ARM IO controller uses it to deliver buttons/switches, N joysticks, mouse (x/y/wheel/buttons) and keyboard/OSD keycodes to the core. Unlike the SPI-clocked first generation, it runs entirely in the core clock domain, with SPI signals oversampled.
- Keyboard/mouse events are queued in a FIFO with a valid/ready handshake instead of a one-cycle strobe.
- Joysticks are parametrised in count and width.
- A status-readback command reports FIFO state.

Parameters:
NUM_JOY, 2, number of joysticks (1..8)
JOY_W, 8, bits per joystick (8, 16, 24 or 32; whole bytes)
FIFO_DEPTH, 8, event FIFO entries (power of 2, 4..64)

Ports:
clk  in  1  core clock; must be >= 4x SPI_CLK frequency
rst_n  in  1  asynchronous active-low reset
SPI_CLK  in  1  SPI clock from IO controller (async)
SPI_SS_IO  in  1  chip select, active low (async)
SPI_MOSI  in  1  serial data in (async)
SPI_MISO  out  1  serial data out
CORE_TYPE  in  8  core identifier returned during the command byte
JOY  out  NUM_JOY*JOY_W  joystick n at [n*JOY_W +: JOY_W]
BUTTONS  out  2  but_sw[1:0]
SWITCHES  out  2  but_sw[3:2]
CONF  out  4  but_sw[7:4]
MOUSE_BUTTONS  out  3  mouse button state
EVT_VALID  out  1  FIFO head valid
EVT_READY  in  1  consumer accepts head
EVT_TYPE  out  3  0=mouse x, 1=mouse y, 2=keycode, 3=OSD key, 4=wheel
EVT_DATA  out  8  event payload
EVT_OVERFLOW  out  1  sticky: an event was dropped
STATUS  out  32  user status word (optional feature)

Behaviour:
- Reset values:
  - All registers clear: JOY, but_sw, MOUSE_BUTTONS and STATUS are 0.
  - FIFO empty; EVT_VALID=0; EVT_OVERFLOW=0; SPI_MISO=0; bit and byte counters 0.
- Synchronisation:
  - SPI_CLK, SPI_SS_IO and SPI_MOSI each pass through a 2-FF synchroniser.
  - Edge detection uses a third stage.
  - Synchronised SS high clears the bit counter (0..7) and byte counter (saturates at 15) and discards partial shift data.
- Shifting, MSB first:
  - On each synchronised SPI_CLK rising edge with SS low, shift in MOSI and increment the bit counter.
  - When the bit counter wraps 7->0, the byte is complete.
  - Byte 0 is the command; bytes 1..n are payload.
- MISO:
  - On SS falling edge, drive CORE_TYPE[7].
  - On each synchronised SPI_CLK falling edge, drive the next bit.
  - Byte 0 shifts CORE_TYPE. For cmd 0x07, payload byte 1 shifts STAT = {EVT_OVERFLOW, fifo_full, level[5:0]}, captured at end of byte 0. All other bytes drive 0.
  - SS high drives 0.
- Commands (payload byte index from 1):
  - 0x01: byte1 -> but_sw.
  - 0x02 / 0x03: legacy aliases of joystick 0 / 1.
  - 0x10+n, n<NUM_JOY: JOY_W/8 payload bytes, MSB byte first, into a staging register. JOY slice n updates atomically on the last byte. SS high before the last byte leaves JOY unchanged. Extra bytes are ignored. n>=NUM_JOY is ignored.
  - 0x04 mouse: byte1 pushes {0,data}; byte2 pushes {1,data}; byte3[2:0] -> MOUSE_BUTTONS (no push); byte4 pushes {4,data}.
  - 0x05: byte1 pushes {2,data}.
  - 0x06: byte1 pushes {3,data}.
  - 0x07: status read (see MISO); reading clears EVT_OVERFLOW at end of byte1.
  - Any other command: payload ignored.
- FIFO:
  - Pop when EVT_VALID and EVT_READY; EVT_TYPE/EVT_DATA change only after a pop or a push into an empty FIFO.
  - Push-to-valid latency is 1 clk.
  - Push while full: entry dropped, EVT_OVERFLOW set.
  - Simultaneous push and pop while full: both succeed, no overflow.
  - Pointers wrap mod FIFO_DEPTH; level counts 0..FIFO_DEPTH.
  - Overflow clear and a new overflow in the same cycle: overflow remains set.
- rst_n asserted mid-transaction: immediate reset of all state; the next transaction needs a fresh SS falling edge.

Optional Feature:
USER_IO_STATUS_EN
- Defined: cmd 0x1E takes 4 payload bytes, MSB first, into a staging register. STATUS updates atomically after byte 4; an incomplete transfer leaves it unchanged.
- Undefined: STATUS is constant 0 and cmd 0x1E is ignored like any unknown command.

Test Plan:
- Send cmd 0x01, payload 0xA5 -> BUTTONS=2'b01, SWITCHES=2'b01, CONF=4'hA. During cmd byte with CORE_TYPE=0xA3, MISO bits read 1,0,1,0,0,0,1,1.
- NUM_JOY=4, JOY_W=16: cmd 0x13, payload 0x12,0x34 -> JOY[63:48]=16'h1234. Repeat with 0x56, then SS high -> JOY slice unchanged.
- cmd 0x04, payload 0x05,0xFB,0x03,0x01 with EVT_READY=1 -> events {0,05},{1,FB},{4,01} in order; MOUSE_BUTTONS=3'b011.
- EVT_READY=0, FIFO_DEPTH=4, send six 0x05 keycodes 0x10..0x15 -> FIFO holds 0x10..0x13, EVT_OVERFLOW=1. cmd 0x07 reads STAT=0xC4 and EVT_OVERFLOW then clears.
- Assert rst_n low mid joystick payload -> all outputs 0. Next full cmd 0x02, payload 0xFF -> JOY[7:0]=0xFF.
- With USER_IO_STATUS_EN: cmd 0x1E, payload DE AD BE EF -> STATUS=32'hDEADBEEF. Without the macro -> STATUS stays 0.

Source files
------------

// File: rtl/user_io_mc_if.sv
// Event stream from the IO-controller SPI slave to the core.
// master: drives VALID/TYPE/DATA/OVERFLOW; slave: drives READY.
interface user_io_mc_if;
  logic       EVT_VALID;
  logic       EVT_READY;
  logic [2:0] EVT_TYPE;
  logic [7:0] EVT_DATA;
  logic       EVT_OVERFLOW;

  modport master (
    output EVT_VALID, EVT_TYPE, EVT_DATA, EVT_OVERFLOW,
    input  EVT_READY
  );
  modport slave (
    input  EVT_VALID, EVT_TYPE, EVT_DATA, EVT_OVERFLOW,
    output EVT_READY
  );
endinterface

// File: rtl/user_io_mc.sv
// Second-generation IO-controller SPI slave, core clock domain.
// Ports: clk/rst_n; SPI_CLK/SPI_SS_IO/SPI_MOSI in, SPI_MISO out;
// CORE_TYPE id; JOY, BUTTONS, SWITCHES, CONF, MOUSE_BUTTONS, STATUS;
// evt: keyboard/mouse event FIFO (valid/ready + sticky overflow).
// Optional: `define USER_IO_STATUS_EN enables cmd 0x1E -> STATUS.
module user_io_mc #(
  parameter int NUM_JOY    = 2,
  parameter int JOY_W      = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     SPI_CLK,
  input  logic                     SPI_SS_IO,
  input  logic                     SPI_MOSI,
  output logic                     SPI_MISO,
  input  logic [7:0]               CORE_TYPE,
  output logic [NUM_JOY*JOY_W-1:0] JOY,
  output logic [1:0]               BUTTONS,
  output logic [1:0]               SWITCHES,
  output logic [3:0]               CONF,
  output logic [2:0]               MOUSE_BUTTONS,
  output logic [31:0]              STATUS,
  user_io_mc_if.master             evt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int JB = JOY_W / 8;

  logic [2:0] sclk_s, ss_s;
  logic [1:0] mosi_s;
  logic       armed;
  logic [2:0] bit_cnt;
  logic [3:0] byte_cnt;
  logic [6:0] sr;
  logic [7:0] cmd, stat_cap, but_sw, byte_v, tx_byte;
  logic [JOY_W-1:0] joy_stg;
  logic       joy_wq;
  logic       act, rise, fall, ss_fall, done, pay;
  logic       push, mb_wr, clr_ovf, bs_wr;
  logic       joy_hit, joy_sh, joy_wr;
  logic [2:0] joy_n, push_t;
  logic [7:0] mem_d [FIFO_DEPTH];
  logic [2:0] mem_t [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  logic       ovf, full, pop, push_ok;

  // armed: SS must be seen high after reset before a transfer counts
  assign act     = armed & ~ss_s[1];
  assign rise    = act & sclk_s[1] & ~sclk_s[2];
  assign fall    = act & ~sclk_s[1] & sclk_s[2];
  assign ss_fall = armed & ~ss_s[1] & ss_s[2];
  assign byte_v  = {sr, mosi_s[1]};
  assign done    = rise & (bit_cnt == 3'd7);
  assign pay     = done & (byte_cnt != 4'd0);

  assign full    = level == LW'(FIFO_DEPTH);
  assign pop     = (level != '0) & evt.EVT_READY;
  assign push_ok = push & (~full | pop);

  assign evt.EVT_VALID    = level != '0;
  assign evt.EVT_TYPE     = mem_t[rp];
  assign evt.EVT_DATA     = mem_d[rp];
  assign evt.EVT_OVERFLOW = ovf;

  assign BUTTONS  = but_sw[1:0];
  assign SWITCHES = but_sw[3:2];
  assign CONF     = but_sw[7:4];

  always_comb begin
    tx_byte = 8'h00;
    if (byte_cnt == 4'd0)
      tx_byte = CORE_TYPE;
    else if (byte_cnt == 4'd1 && cmd == 8'h07)
      tx_byte = stat_cap;
  end

  always_comb begin
    joy_hit = 1'b0;
    joy_n   = 3'd0;
    if (cmd == 8'h02) begin
      joy_hit = 1'b1;
    end else if (cmd == 8'h03 && NUM_JOY > 1) begin
      joy_hit = 1'b1;
      joy_n   = 3'd1;
    end else if (cmd[7:4] == 4'h1 &&
                 int'(cmd[3:0]) < NUM_JOY) begin
      joy_hit = 1'b1;
      joy_n   = cmd[2:0];
    end
  end

`ifdef USER_IO_STATUS_EN
  logic [31:0] st_stg;
  logic        st_sh, st_wr, st_wq;
`endif

  always_comb begin
    push    = 1'b0;
    push_t  = 3'd0;
    mb_wr   = 1'b0;
    clr_ovf = 1'b0;
    bs_wr   = 1'b0;
    joy_sh  = 1'b0;
    joy_wr  = 1'b0;
`ifdef USER_IO_STATUS_EN
    st_sh   = 1'b0;
    st_wr   = 1'b0;
`endif
    if (pay) begin
      unique case (1'b1)
        cmd == 8'h01: bs_wr = byte_cnt == 4'd1;
        cmd == 8'h04: begin
          push = (byte_cnt == 4'd1) |
                 (byte_cnt == 4'd2) |
                 (byte_cnt == 4'd4);
          push_t = (byte_cnt == 4'd2) ? 3'd1 :
                   (byte_cnt == 4'd4) ? 3'd4 : 3'd0;
          mb_wr = byte_cnt == 4'd3;
        end
        cmd == 8'h05: begin
          push   = byte_cnt == 4'd1;
          push_t = 3'd2;
        end
        cmd == 8'h06: begin
          push   = byte_cnt == 4'd1;
          push_t = 3'd3;
        end
        cmd == 8'h07: clr_ovf = byte_cnt == 4'd1;
        joy_hit: begin
          joy_sh = int'(byte_cnt) <= JB;
          joy_wr = int'(byte_cnt) == JB;
        end
`ifdef USER_IO_STATUS_EN
        cmd == 8'h1E: begin
          st_sh = byte_cnt <= 4'd4;
          st_wr = byte_cnt == 4'd4;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s   <= '0;
      ss_s     <= '0;
      mosi_s   <= '0;
      armed    <= 1'b0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      sr       <= '0;
      cmd      <= '0;
      stat_cap <= '0;
      but_sw   <= '0;
      MOUSE_BUTTONS <= '0;
      joy_stg  <= '0;
      joy_wq   <= 1'b0;
      JOY      <= '0;
      SPI_MISO <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[1:0], SPI_CLK};
      ss_s   <= {ss_s[1:0], SPI_SS_IO};
      mosi_s <= {mosi_s[0], SPI_MOSI};
      if (ss_s[1]) armed <= 1'b1;
      if (!act) begin
        bit_cnt  <= '0;
        byte_cnt <= '0;
        sr       <= '0;
      end else if (rise) begin
        bit_cnt <= bit_cnt + 3'd1;
        sr      <= byte_v[6:0];
        if (done && byte_cnt != 4'hF)
          byte_cnt <= byte_cnt + 4'd1;
        if (done && byte_cnt == 4'd0) begin
          cmd      <= byte_v;
          stat_cap <= {ovf, full, 6'(level)};
        end
      end
      if (!act)
        SPI_MISO <= 1'b0;
      else if (ss_fall)
        SPI_MISO <= CORE_TYPE[7];
      else if (fall)
        SPI_MISO <= tx_byte[~bit_cnt];
      if (bs_wr) but_sw <= byte_v;
      if (mb_wr) MOUSE_BUTTONS <= byte_v[2:0];
      // bytes land at their final position; slice copies next clk
      if (joy_sh)
        joy_stg[(JB - int'(byte_cnt)) * 8 +: 8] <= byte_v;
      joy_wq <= joy_wr;
      for (int i = 0; i < NUM_JOY; i++)
        if (joy_wq && int'(joy_n) == i)
          JOY[i*JOY_W +: JOY_W] <= joy_stg;
    end
  end

`ifdef USER_IO_STATUS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_stg <= '0;
      st_wq  <= 1'b0;
      STATUS <= '0;
    end else begin
      if (st_sh)
        st_stg[(4 - int'(byte_cnt)) * 8 +: 8] <= byte_v;
      st_wq <= st_wr;
      if (st_wq) STATUS <= st_stg;
    end
  end
`else
  assign STATUS = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      ovf   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_d[i] <= '0;
        mem_t[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_d[wp] <= byte_v;
        mem_t[wp] <= push_t;
        wp <= wp + AW'(1);
      end
      if (pop) rp <= rp + AW'(1);
      level <= level + LW'(push_ok) - LW'(pop);
      // a new drop wins over a same-cycle status-read clear
      ovf <= (ovf & ~clr_ovf) | (push & full & ~pop);
    end
  end
endmodule

// File: tb/tb_user_io_mc.sv
// Bench for user_io_mc: SPI master driver, command-level model,
// per-cycle compare process and literal spot checks.
module tb_user_io_mc;
  localparam int NJ = 4;
  localparam int JW = 16;
  localparam int FD = 4;
  localparam int JB = JW / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic SPI_CLK = 1'b0;
  logic SPI_SS_IO = 1'b1;
  logic SPI_MOSI = 1'b0;
  logic SPI_MISO;
  logic [7:0] CORE_TYPE = 8'hA3;
  logic [NJ*JW-1:0] JOY;
  logic [1:0] BUTTONS, SWITCHES;
  logic [3:0] CONF;
  logic [2:0] MOUSE_BUTTONS;
  logic [31:0] STATUS;

  user_io_mc_if evt ();

  user_io_mc #(
    .NUM_JOY(NJ), .JOY_W(JW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .SPI_CLK(SPI_CLK), .SPI_SS_IO(SPI_SS_IO),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO),
    .CORE_TYPE(CORE_TYPE), .JOY(JOY),
    .BUTTONS(BUTTONS), .SWITCHES(SWITCHES),
    .CONF(CONF), .MOUSE_BUTTONS(MOUSE_BUTTONS),
    .STATUS(STATUS), .evt(evt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] t;
    logic [7:0] d;
  } ev_t;

  logic [JW-1:0] m_joy [NJ];
  logic [7:0]  m_bs;
  logic [2:0]  m_mb;
  logic        m_ovf;
  logic [31:0] m_st;
  logic [7:0]  exp_stat;
  ev_t         mq [$];

  logic [7:0] tx [16];
  logic [7:0] rx [16];
  logic [NJ*JW-1:0] ej;
  int checks = 0;
  int fails = 0;
  int npop = 0;
  int n0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NJ; i++) m_joy[i] = '0;
    m_bs = '0;
    m_mb = '0;
    m_ovf = 1'b0;
    m_st = '0;
    mq.delete();
  endfunction

  function automatic int joy_idx(logic [7:0] c);
    if (c == 8'h02) return 0;
    if (c == 8'h03) return 1;
    if (c[7:4] == 4'h1 && int'(c[3:0]) < NJ)
      return int'(c[3:0]);
    return -1;
  endfunction

  function automatic void m_push(logic [2:0] t,
                                 logic [7:0] d);
    if (mq.size() < FD) mq.push_back({t, d});
    else m_ovf = 1'b1;
  endfunction

  // called when byte b of the current transfer is complete
  function automatic void m_byte(int b);
    logic [7:0] c;
    logic [JW-1:0] v;
    int j;
    c = tx[0];
    j = joy_idx(c);
    if (b == 0) begin
      if (c == 8'h07)
        exp_stat = {m_ovf, mq.size() == FD,
                    6'(mq.size())};
      return;
    end
    case (c)
      8'h01: if (b == 1) m_bs = tx[1];
      8'h04: begin
        if (b == 1) m_push(3'd0, tx[1]);
        if (b == 2) m_push(3'd1, tx[2]);
        if (b == 3) m_mb = tx[3][2:0];
        if (b == 4) m_push(3'd4, tx[4]);
      end
      8'h05: if (b == 1) m_push(3'd2, tx[1]);
      8'h06: if (b == 1) m_push(3'd3, tx[1]);
      8'h07: if (b == 1) m_ovf = 1'b0;
`ifdef USER_IO_STATUS_EN
      8'h1E: if (b == 4)
        m_st = {tx[1], tx[2], tx[3], tx[4]};
`endif
      default: ;
    endcase
    if (j >= 0 && b == JB) begin
      v = '0;
      for (int k = 1; k <= JB; k++)
        v = {v[JW-9:0], tx[k]};
      m_joy[j] = v;
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NJ; i++)
        ej[i*JW +: JW] = m_joy[i];
      chk("joy", JOY, ej);
      chk("but_sw", {CONF, SWITCHES, BUTTONS}, m_bs);
      chk("mouse_btn", MOUSE_BUTTONS, m_mb);
      chk("status", STATUS, m_st);
      chk("ovf", evt.EVT_OVERFLOW, m_ovf);
      chk("miso_idle", SPI_MISO, 1'b0);
      chk("valid", evt.EVT_VALID, mq.size() != 0);
      if (mq.size() != 0)
        chk("head", {evt.EVT_TYPE, evt.EVT_DATA}, mq[0]);
    end
    if (evt.EVT_VALID && evt.EVT_READY) begin
      if (mq.size() == 0)
        chk("pop_empty", evt.EVT_VALID, 1'b0);
      else begin
        chk("pop_ev", {evt.EVT_TYPE, evt.EVT_DATA}, mq[0]);
        void'(mq.pop_front());
        npop++;
      end
    end
  end

  task automatic settle();
    repeat (8) @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input int n, input bit keep_ss);
    chk_en = 1'b0;
    SPI_SS_IO = 1'b0;
    for (int b = 0; b < n; b++) begin
      for (int i = 7; i >= 0; i--) begin
        SPI_MOSI = tx[b][i];
        #50;
        rx[b][i] = SPI_MISO;
        SPI_CLK = 1'b1;
        if (i == 0) m_byte(b);
        #50;
        SPI_CLK = 1'b0;
      end
    end
    if (!keep_ss) begin
      #50;
      SPI_SS_IO = 1'b1;
      settle();
    end
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 evt.EVT_READY = r;
  endtask

  task automatic lit_reset_checks();
    @(negedge clk);
    chk("rst_joy", JOY, '0);
    chk("rst_bs", {CONF, SWITCHES, BUTTONS}, 8'h00);
    chk("rst_mb", MOUSE_BUTTONS, 3'd0);
    chk("rst_status", STATUS, 32'h0);
    chk("rst_valid", evt.EVT_VALID, 1'b0);
    chk("rst_ovf", evt.EVT_OVERFLOW, 1'b0);
    chk("rst_miso", SPI_MISO, 1'b0);
  endtask

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL timeout");
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

  initial begin
    evt.EVT_READY = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    lit_reset_checks();
    @(posedge clk);
    #1 rst_n = 1'b1;
    settle();

    tx[0] = 8'h01; tx[1] = 8'hA5;
    xfer(2, 1'b0);
    chk("core_type_bits", rx[0], 8'hA3);
    chk("miso_byte1_zero", rx[1], 8'h00);
    chk("buttons", BUTTONS, 2'b01);
    chk("switches", SWITCHES, 2'b01);
    chk("conf", CONF, 4'hA);

    tx[0] = 8'h13; tx[1] = 8'h12; tx[2] = 8'h34;
    xfer(3, 1'b0);
    chk("joy3", JOY[63:48], 16'h1234);
    tx[0] = 8'h13; tx[1] = 8'h56;
    xfer(2, 1'b0);
    chk("joy3_partial", JOY[63:48], 16'h1234);

    tx[0] = 8'h11; tx[1] = 8'hAA;
    tx[2] = 8'hBB; tx[3] = 8'hCC;
    xfer(4, 1'b0);
    chk("joy1_extra", JOY[31:16], 16'hAABB);
    tx[0] = 8'h17; tx[1] = 8'h11; tx[2] = 8'h22;
    xfer(3, 1'b0);
    tx[0] = 8'h03; tx[1] = 8'hC3; tx[2] = 8'h5A;
    xfer(3, 1'b0);
    chk("joy1_legacy", JOY[31:16], 16'hC35A);

    set_ready(1'b1);
    n0 = npop;
    tx[0] = 8'h04; tx[1] = 8'h05; tx[2] = 8'hFB;
    tx[3] = 8'h03; tx[4] = 8'h01;
    xfer(5, 1'b0);
    chk("mouse_btn_lit", MOUSE_BUTTONS, 3'b011);
    chk("mouse_pops", npop - n0, 3);

    set_ready(1'b0);
    for (int k = 0; k < 6; k++) begin
      tx[0] = 8'h05; tx[1] = 8'(8'h10 + k);
      xfer(2, 1'b0);
    end
    chk("ovf_lit", evt.EVT_OVERFLOW, 1'b1);
    chk("head_lit", {evt.EVT_TYPE, evt.EVT_DATA},
        {3'd2, 8'h10});
    tx[0] = 8'h07; tx[1] = 8'h00;
    xfer(2, 1'b0);
    chk("stat_lit", rx[1], 8'hC4);
    chk("stat_model", rx[1], exp_stat);
    chk("ovf_clr_lit", evt.EVT_OVERFLOW, 1'b0);
    n0 = npop;
    set_ready(1'b1);
    settle();
    chk("drain_pops", npop - n0, 4);

    tx[0] = 8'h06; tx[1] = 8'h77;
    xfer(2, 1'b0);

    tx[0] = 8'h1E; tx[1] = 8'hDE; tx[2] = 8'hAD;
    tx[3] = 8'hBE; tx[4] = 8'hEF;
    xfer(5, 1'b0);
`ifdef USER_IO_STATUS_EN
    chk("status_lit", STATUS, 32'hDEADBEEF);
`else
    chk("status_lit", STATUS, 32'h0);
`endif
    tx[0] = 8'h1E; tx[1] = 8'h11; tx[2] = 8'h22;
    xfer(3, 1'b0);

    tx[0] = 8'h10; tx[1] = 8'hAB;
    xfer(2, 1'b1);
    #3 rst_n = 1'b0;
    m_reset();
    lit_reset_checks();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 SPI_SS_IO = 1'b1;
    settle();
    tx[0] = 8'h02; tx[1] = 8'h00; tx[2] = 8'hFF;
    xfer(3, 1'b0);
    chk("joy0_after_rst", JOY[7:0], 8'hFF);
    chk("joy_hi_after_rst", JOY[63:16], 48'h0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end
endmodule
